// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared definitions for the Ethernet reply transmit arbiter
package eth_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam int REQ_ARP     = 0;
    localparam int REQ_ICMP    = 1;
    localparam int DEFAULT_IFG = 12;
    localparam int MAX_REQ     = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: request vector and last index in, one-hot winner out
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant
);

    logic          found;
    logic [IW-1:0] idx;

    // Walk the ring starting just after the last owner; the last owner is visited last.
    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(i_last) + i) % N);
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ethernet_reply_tx_arbiter.sv
// rtl/ethernet_reply_tx_arbiter.sv - round-robin share of the byte-wide TX path; ETH_TX_ARB_STATS_EN adds o_frame_cnt
module ethernet_reply_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int IFG_CYCLES    = DEFAULT_IFG,
    parameter int START_TIMEOUT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req,
    output logic [N_REQ-1:0]     o_start,
    input  logic [N_REQ*8-1:0]   i_word,
    input  logic [N_REQ-1:0]     i_valid,
    output logic [7:0]           o_word,
    output logic                 o_valid,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_timeout
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]  o_frame_cnt
`endif
);

    localparam int         IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] TO_LAST  = 4'(START_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    grant_idx, last_idx, pick_idx;
    logic [N_REQ-1:0] pick;
    logic [3:0]       start_cnt;
    logic [7:0]       gap_cnt;
    logic             g_valid;
    logic [7:0]       g_word;
    logic             start_expired;
    logic             frame_done;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_last  (last_idx),
        .o_grant (pick)
    );

    assign pick_idx      = IW'(onehot_to_idx(MAX_REQ'(pick)));
    assign g_valid       = i_valid[grant_idx];
    assign g_word        = i_word[{grant_idx, 3'b000} +: 8];
    assign start_expired = (state == ST_START) && !g_valid && (start_cnt == TO_LAST);
    assign frame_done    = (state == ST_SEND) && !g_valid;
    assign o_busy        = (state != ST_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The SEND cycle that sees valid drop already counts as the first gap cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (|i_req) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (g_valid) begin
                    state_nxt = ST_SEND;
                end else if (start_cnt == TO_LAST) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_SEND: begin
                if (!g_valid) begin
                    state_nxt = (IFG_CYCLES == 1) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt >= GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_start   <= '0;
            o_grant   <= '0;
            o_word    <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            grant_idx <= '0;
            last_idx  <= IW'(N_REQ - 1);
            start_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            o_start <= '0;
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|i_req) begin
                        o_start   <= pick;
                        o_grant   <= pick;
                        grant_idx <= pick_idx;
                        start_cnt <= '0;
                    end
                end
                ST_START, ST_SEND: begin
                    if (g_valid) begin
                        o_valid <= 1'b1;
                        o_word  <= g_word;
                    end
                    if ((state == ST_START) && !g_valid) begin
                        start_cnt <= start_cnt + 4'd1;
                    end
                    if (start_expired) begin
                        o_timeout <= 1'b1;
                    end
                    // Ownership ends here; the pointer moves so the next search starts after this owner.
                    if (start_expired || frame_done) begin
                        o_grant  <= '0;
                        gap_cnt  <= 8'd1;
                        last_idx <= grant_idx;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [15:0] frame_cnt [N_REQ];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                frame_cnt[i] <= '0;
            end
        end else if (frame_done) begin
            frame_cnt[grant_idx] <= frame_cnt[grant_idx] + 16'd1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_frame_cnt
        assign o_frame_cnt[16*g +: 16] = frame_cnt[g];
    end
`endif

endmodule

// File: tb/tb_ethernet_reply_tx_arbiter.sv
// tb/tb_ethernet_reply_tx_arbiter.sv - scoreboard bench for ethernet_reply_tx_arbiter
module tb_ethernet_reply_tx_arbiter;
    import eth_tx_pkg::*;

    localparam int N   = 2;
    localparam int IFG = 12;
    localparam int STO = 4;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [N-1:0]     i_req, o_start, i_valid, o_grant;
    logic [N*8-1:0]   i_word;
    logic [7:0]       o_word;
    logic             o_valid, o_busy, o_timeout;
`ifdef ETH_TX_ARB_STATS_EN
    logic [N*16-1:0]  o_frame_cnt;
`endif

    ethernet_reply_tx_arbiter #(
        .N_REQ         (N),
        .IFG_CYCLES    (IFG),
        .START_TIMEOUT (STO)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (i_req),
        .o_start   (o_start),
        .i_word    (i_word),
        .i_valid   (i_valid),
        .o_word    (o_word),
        .o_valid   (o_valid),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .o_frame_cnt (o_frame_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int idx;
        bit gap;
        bit mute;
    } grant_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } byte_t;

    grant_t gq[$];
    byte_t  dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_last = N - 1;
    int frames_left[N];
    bit mute[N];
    int fix_len = 0;
    int rst_at = -1;
    bit tx_active = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a start strobe or a byte.
    int owner = 0, last_vcyc = -1000, exp_to_cyc = -1;
    bit had_data = 0, prev_busy = 0, prev_to = 0, prev_start = 0;
    always @(negedge i_clk) begin
        grant_t g;
        byte_t  b;
        if (!i_reset) begin
            if (prev_start) chk("start_one_cycle", 64'(o_start), 64'(0));
            prev_start = (o_start != '0);
            if (o_start != '0) begin
                if (gq.size() == 0) begin
                    fail_now("unexpected_start", int'(o_start), 0);
                end else begin
                    g = gq.pop_front();
                    chk("start_onehot", 64'(o_start), 64'(1) << g.idx);
                    chk("grant_at_start", 64'(o_grant), 64'(1) << g.idx);
                    chk("busy_at_start", 64'(o_busy), 64'(1));
                    if (g.gap) chk("start_gap", 64'(cyc - last_vcyc), 64'(IFG + 1));
                    if (g.mute) exp_to_cyc = cyc + STO;
                    owner    = g.idx;
                    had_data = 0;
                end
            end
            if (o_valid) begin
                if (dq.size() == 0) begin
                    fail_now("unexpected_valid", int'(o_word), -1);
                end else begin
                    b = dq.pop_front();
                    chk("byte_value", 64'(o_word), 64'(b.data));
                    chk("byte_latency", 64'(cyc - b.cyc), 64'(1));
                    chk("grant_in_frame", 64'(o_grant), 64'(1) << owner);
                end
                last_vcyc = cyc;
                had_data  = 1;
            end
            if (prev_busy && !o_busy && had_data) chk("busy_fall", 64'(cyc - last_vcyc), 64'(IFG));
            if (o_timeout && !prev_to) chk("timeout_cycle", 64'(cyc), 64'(exp_to_cyc));
            prev_busy = o_busy;
            prev_to   = o_timeout;
        end else begin
            prev_busy  = 0;
            prev_to    = 0;
            prev_start = 0;
            had_data   = 0;
        end
    end

    // Transmitter models: answer a start strobe with a random-length frame, noise on the other channels.
    initial begin
        int k, len, d;
        logic [7:0] b8;
        forever begin
            @(negedge i_clk);
            if (!i_reset && o_start != '0) begin
                tx_active = 1;
                k = 0;
                for (int i = 0; i < N; i++) if (o_start[i]) k = i;
                if (frames_left[k] > 0) frames_left[k]--;
                if (frames_left[k] == 0) i_req[k] = 1'b0;
                if (mute[k]) begin
                    mute[k] = 0;
                end else begin
                    len = (fix_len > 0) ? fix_len : $urandom_range(1, 24);
                    d = $urandom_range(0, 2);
                    repeat (d) begin
                        i_valid    = N'($urandom_range(0, (1 << N) - 1));
                        i_valid[k] = 1'b0;
                        i_word     = {N{8'hAA}};
                        @(negedge i_clk);
                    end
                    for (int n = 0; n < len; n++) begin
                        if (n == rst_at) begin
                            #2 i_reset = 1'b1;
                            #1;
                            chk("reset_valid", 64'(o_valid), 64'(0));
                            chk("reset_grant", 64'(o_grant), 64'(0));
                            chk("reset_busy", 64'(o_busy), 64'(0));
                            chk("reset_start", 64'(o_start), 64'(0));
                            chk("reset_word", 64'(o_word), 64'(0));
                            dq.delete();
                            i_req   = '0;
                            i_valid = '0;
                            for (int i = 0; i < N; i++) frames_left[i] = 0;
                            rst_at     = -1;
                            model_last = N - 1;
                            repeat (2) @(negedge i_clk);
                            #2 i_reset = 1'b0;
                            break;
                        end
                        b8         = 8'($urandom_range(0, 255));
                        i_valid    = N'($urandom_range(0, (1 << N) - 1));
                        i_valid[k] = 1'b1;
                        i_word     = {N{8'hAA}};
                        i_word[k*8 +: 8] = b8;
                        dq.push_back('{b8, cyc});
                        @(negedge i_clk);
                    end
                    i_valid = '0;
                end
                tx_active = 0;
            end
        end
    end

    // Reference model: requesters with frames outstanding are served in ring order after the last owner.
    task automatic run_batch(input int p0, input int p1, input bit mute_icmp, input int flen, input int rbyte);
        int  pend[N];
        int  w;
        bit  found, first, prev_data, mute_left, m, done;
        pend      = '{p0, p1};
        first     = 1;
        prev_data = 0;
        mute_left = mute_icmp;
        while (pend[0] + pend[1] > 0) begin
            found = 0;
            w = 0;
            for (int s = 1; s <= N; s++) begin
                if (!found && pend[(model_last + s) % N] > 0) begin
                    w     = (model_last + s) % N;
                    found = 1;
                end
            end
            m = mute_left && (w == REQ_ICMP);
            if (m) mute_left = 0;
            gq.push_back('{w, !first && prev_data, m});
            prev_data  = !m;
            first      = 0;
            pend[w]--;
            model_last = w;
        end
        frames_left[0] = p0;
        frames_left[1] = p1;
        mute[REQ_ICMP] = mute_icmp;
        fix_len        = flen;
        rst_at         = rbyte;
        i_req          = {p1 > 0, p0 > 0};
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge i_clk);
            if (gq.size() == 0 && dq.size() == 0 && !o_busy && i_req == '0 && !tx_active && !i_reset)
                done = 1;
        end
        if (!done) begin
            fail_now("batch_timeout", gq.size(), 0);
            gq.delete();
            dq.delete();
        end
    endtask

    initial begin
        int p0, p1;
        i_reset = 1'b1;
        i_req   = '0;
        i_valid = '0;
        i_word  = '0;
        for (int i = 0; i < N; i++) begin
            frames_left[i] = 0;
            mute[i]        = 0;
        end
        repeat (2) @(negedge i_clk);
        chk("rst_start", 64'(o_start), 64'(0));
        chk("rst_word", 64'(o_word), 64'(0));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_grant", 64'(o_grant), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_timeout", 64'(o_timeout), 64'(0));
        i_reset = 1'b0;
        @(negedge i_clk);

        run_batch(1, 1, 0, 0, -1);
        run_batch(0, 1, 0, 50, -1);
        run_batch(3, 3, 0, 0, -1);
        run_batch(0, 1, 0, 30, -1);
        run_batch(1, 0, 0, 0, -1);
        chk("timeout_clear_before", 64'(o_timeout), 64'(0));
        run_batch(1, 1, 1, 0, -1);
        chk("timeout_sticky", 64'(o_timeout), 64'(1));
        run_batch(1, 0, 0, 30, 20);
        chk("timeout_after_reset", 64'(o_timeout), 64'(0));
`ifdef ETH_TX_ARB_STATS_EN
        chk("frame_cnt_after_reset", 64'(o_frame_cnt), 64'(0));
`endif
        run_batch(1, 1, 0, 0, -1);

        for (int r = 0; r < 12; r++) begin
            p0 = $urandom_range(0, 2);
            p1 = $urandom_range(0, 2);
            if (p0 + p1 == 0) p0 = 1;
            run_batch(p0, p1, 0, 0, -1);
        end

        repeat (5) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ethernet_reply_tx_arbiter.md
# ethernet_reply_tx_arbiter

Round-robin scheduler that shares the single byte-wide Ethernet transmit path between several reply transmitters (ARP reply, ICMP reply, …). It picks one pending requester and fires that transmitter's one-cycle start strobe. It then muxes the selected transmitter's byte stream onto the shared output, detects end of frame, and enforces an inter-frame gap before the next grant.

## Interface
- `N_REQ`, 2, number of requesters (index 0 = ARP reply, 1 = ICMP reply); range 2..8
- `IFG_CYCLES`, 12, idle cycles forced between frames; range 1..255
- `START_TIMEOUT`, 4, cycles allowed from start strobe to first valid byte; range 2..15

Ports:
- `i_clk`  in  1  single clock, all logic rising-edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_req`  in  N_REQ  per-requester frame-pending level, held until its `o_start` bit pulses
- `o_start`  out  N_REQ  one-hot, one-cycle start strobe to the transmitter's ready input
- `i_word`  in  N_REQ*8  transmitter bytes, requester k at bits [8k+7:8k]
- `i_valid`  in  N_REQ  transmitter byte valids
- `o_word`  out  8  shared transmit byte
- `o_valid`  out  1  shared transmit valid
- `o_grant`  out  N_REQ  one-hot current owner, 0 when idle
- `o_busy`  out  1  high in any state except IDLE
- `o_timeout`  out  1  sticky; set when a start strobe gets no byte within START_TIMEOUT

## Operation
- FSM states: IDLE, START, SEND, GAP.
- IDLE: if any `i_req` bit is set, select the winner by round-robin. The search begins at the index after the last granted one; after reset, the last granted index is N_REQ-1, so requester 0 wins first. Register `o_grant` and pulse the winner's `o_start` bit, then go to START.
- START: count cycles.
  - Granted `i_valid` high → go to SEND.
  - Count reaches START_TIMEOUT with no valid → set `o_timeout`, clear `o_grant`, go to GAP.
- SEND: `o_word`/`o_valid` follow the granted transmitter through a register. When granted `i_valid` falls, go to GAP. Frames of any length are accepted; there is no byte counter limit.
- GAP: drive `o_valid`=0 for IFG_CYCLES cycles, then go to IDLE. The round-robin pointer is updated on entry to GAP.
- Non-granted `i_valid`/`i_word` are ignored in every state.
- `i_req` is sampled only in IDLE. A requester that deasserts before being granted is simply skipped.
- `o_timeout` is cleared only by reset.
- Reset values: `o_start`=0, `o_word`=0, `o_valid`=0, `o_grant`=0, `o_busy`=0, `o_timeout`=0, state IDLE, pointer N_REQ-1, counters 0.
- Reset mid-frame: all outputs are 0 immediately (asynchronous). The aborted transmitter is not restarted; its requester must re-request.

## Timing
- `i_req` first seen high in IDLE at edge t:
  - `o_start`, `o_grant`, and `o_busy` are high after edge t.
  - `o_start` is low again after edge t+1.
- Transmitter byte n presented with `i_valid` at edge u appears on `o_word`/`o_valid` after edge u+1. Output latency is a fixed 1 cycle.
- The GAP count starts in the cycle after the last granted valid byte. The earliest next `o_start` is IFG_CYCLES+1 cycles after the last `o_valid`=1 cycle.
- Timeout: with the strobe at edge t and no valid, `o_timeout` sets at edge t+START_TIMEOUT.
- Multiple simultaneous requests always resolve in one cycle. No combinational path exists from any input to any output.

## Configuration
- `ETH_TX_ARB_STATS_EN` defined: adds output `o_frame_cnt` (N_REQ*16). It holds per-requester 16-bit frame counters, incremented on SEND→GAP and wrapping at 65535→0; reset to 0.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `eth_tx_pkg` holds:
  - the FSM state encoding
  - requester index constants `REQ_ARP`=0, `REQ_ICMP`=1
  - the default IFG of 12
- Sub-module `rr_pick`: combinational round-robin priority encoder (request vector and last index in, one-hot winner out). Reusable by the RX side.

## Test plan
- **Single ICMP frame:** `i_req`=2'b10; the transmitter sends 50 bytes. Expect `o_start`=2'b10 for 1 cycle and `o_grant`=2'b10, then 50 `o_valid` bytes matching the input delayed by 1. `o_busy` falls 12 cycles after the last byte.
- **Simultaneous requests:** after reset, `i_req`=2'b11 held. Expect ARP granted first, then ICMP. The second `o_start` comes exactly 13 cycles after the ARP frame's last `o_valid`.
- **Fairness:** both requests held for 6 frames. Expect grants to alternate 0,1,0,1,0,1.
- **Noise rejection:** toggle `i_valid[0]` with bytes 0xAA while ICMP is granted. `o_word`/`o_valid` carry ICMP data only.
- **Timeout:** grant requester 1, which never raises valid. `o_timeout`=1 four cycles after the strobe; the FSM passes through GAP to IDLE and then serves requester 0.
- **Reset mid-frame:** assert `i_reset` at byte 20. All outputs are 0 at once. After release, a new request is granted normally; with stats enabled, `o_frame_cnt` reads 0.
